// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Types and constants shared by the fetch front end and the
//            control unit of the single-cycle MIPS CPU.
// Contents : pcsrc_t       - next-PC select encoding (control unit matches it)
//            fetch_state_t - fetch FSM state encoding
//            WORD_BYTES    - bytes per instruction word
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_EXEC = 2'b10,
    S_TRAP = 2'b11
  } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Request/response instruction-memory port.
// Ports    : imem_req    - fetch request valid (fetch -> memory)
//            imem_addr   - fetch byte address  (fetch -> memory)
//            imem_ready  - request accepted    (memory -> fetch)
//            imem_rvalid - read data valid     (memory -> fetch)
//            imem_rdata  - instruction word    (memory -> fetch)
// Modports : master (fetch side), slave (memory side)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_npc_gen.sv
`default_nettype none
// ============================================================================
// Module   : npc_gen
// Purpose  : Combinational next-PC generator (sequential, branch, jr, j/jal).
//            All arithmetic wraps modulo 2^32.
// Ports    : pc4   in  32 - address of the following instruction
//            inst  in  32 - current instruction word
//            ra    in  32 - rs register value (jr target)
//            pcsrc in   2 - next-PC select
//            npc   out 32 - next PC
// Revision : 1.0 - initial release
// ============================================================================
module npc_gen
  import cpu_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] inst,
  input  logic [31:0] ra,
  input  pcsrc_t      pcsrc,
  output logic [31:0] npc
);

  logic [31:0] w_br_off;

  // Sign-extended word offset, shifted to a byte offset.
  assign w_br_off = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    npc = pc4;
    case (pcsrc)
      PC_SEQ:  npc = pc4;
      PC_BR:   npc = pc4 + w_br_off;
      PC_JR:   npc = ra;
      PC_J:    npc = {pc4[31:28], inst[25:0], 2'b00};
      default: npc = pc4;
    endcase
  end

endmodule : npc_gen
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end: owns the PC, fetches through the
//            request/response memory port and presents one instruction per
//            execute window. A misaligned next PC traps until reset.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            imem          - instruction-memory port (master side)
//            inst, pc, pc4 - latched instruction, its address, address + 4
//            inst_valid    - execute window
//            pcsrc, ra     - next-PC select and jr target
//            stall         - extend the execute window
//            misalign_err  - sticky misaligned-next-PC flag
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  output logic [31:0]        inst,
  output logic [31:0]        pc,
  output logic [31:0]        pc4,
  output logic               inst_valid,
  input  logic [1:0]         pcsrc,
  input  logic [31:0]        ra,
  input  logic               stall,
  output logic               misalign_err
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic         r_misalign;
  logic [31:0]  w_pc4;
  logic [31:0]  w_npc;

  assign w_pc4 = r_pc + 32'(WORD_BYTES);

  npc_gen u_npc_gen (
    .pc4   (w_pc4),
    .inst  (r_inst),
    .ra    (ra),
    .pcsrc (pcsrc_t'(pcsrc)),
    .npc   (w_npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_inst     <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          // rvalid is deliberately ignored here: it may be a leftover
          // response from a fetch aborted by reset.
          if (imem.imem_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            r_inst  <= imem.imem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            if (w_npc[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
              r_state    <= S_TRAP;
            end else begin
              r_pc    <= w_npc;
              r_state <= S_REQ;
            end
          end
        end
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Handshake outputs are forced low during reset so nothing downstream
  // acts on state that is about to be discarded.
  assign imem.imem_req  = (r_state == S_REQ) && !rst;
  assign imem.imem_addr = r_pc;
  assign inst_valid     = (r_state == S_EXEC) && !rst;
  assign misalign_err   = r_misalign && !rst;
  assign inst           = r_inst;
  assign pc             = r_pc;
  assign pc4            = w_pc4;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, pc4;
  logic        inst_valid;
  logic [1:0]  pcsrc;
  logic [31:0] ra;
  logic        stall;
  logic        misalign_err;
  int          checks   = 0;
  int          failures = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus.master),
    .inst         (inst),
    .pc           (pc),
    .pc4          (pc4),
    .inst_valid   (inst_valid),
    .pcsrc        (pcsrc),
    .ra           (ra),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-waitstate fetch: checks the request, then returns word one cycle later.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    chk("req_high", 32'(bus.imem_req), 32'd1);
    chk("req_addr", bus.imem_addr, addr);
    chk("req_ivalid", 32'(inst_valid), 32'd0);
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    chk("wait_req", 32'(bus.imem_req), 32'd0);
    chk("wait_ivalid", 32'(inst_valid), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("exec_ivalid", 32'(inst_valid), 32'd1);
    chk("exec_inst", inst, word);
    chk("exec_pc", pc, addr);
    chk("exec_pc4", pc4, addr + 32'd4);
  endtask

  task automatic exec(input logic [1:0] sel, input logic [31:0] rav);
    pcsrc = sel;
    ra    = rav;
    stall = 1'b0;
    tick();
    pcsrc = 2'b00;
    ra    = 32'hDEAD_0001;
  endtask

  logic [31:0] held_inst;

  initial begin
    rst = 1'b1; pcsrc = 2'b00; ra = 32'h0; stall = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_ivalid", 32'(inst_valid), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    #1;

    // Sequential addi stream: 0x0, 0x4, 0x8, then on to 0x10
    fetch(32'h0, 32'h2008_0005); exec(2'b00, 0);
    fetch(32'h4, 32'h2008_0005); exec(2'b00, 0);
    fetch(32'h8, 32'h2008_0005); exec(2'b00, 0);
    fetch(32'hC, 32'h0000_0000); exec(2'b00, 0);

    // Backward branch: 0x14 - 8 = 0x0C
    fetch(32'h10, 32'h1000_FFFE); exec(2'b01, 0);
    fetch(32'h0C, 32'h0000_0000); exec(2'b00, 0);
    // Forward branch: 0x14 + 12 = 0x20
    fetch(32'h10, 32'h1000_0003); exec(2'b01, 0);

    // jr to 0x0040_0000, then j to 0x0400_0000, then jr to 0x1234_5678
    fetch(32'h20, 32'h0100_0008); exec(2'b10, 32'h0040_0000);
    fetch(32'h0040_0000, 32'h0900_0000); exec(2'b11, 0);
    fetch(32'h0400_0000, 32'h0300_0008); exec(2'b10, 32'h1234_5678);

    // Waitstates: ready low 3 cycles, rvalid 4 cycles after acceptance
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", 32'(bus.imem_req), 32'd1);
      chk("ws_addr", bus.imem_addr, 32'h1234_5678);
      tick();
    end
    chk("ws_req_last", 32'(bus.imem_req), 32'd1);
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_wait_req", 32'(bus.imem_req), 32'd0);
      chk("ws_wait_ivalid", 32'(inst_valid), 32'd0);
      tick();
    end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2109_0007;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("ws_inst", inst, 32'h2109_0007);
    chk("ws_ivalid", 32'(inst_valid), 32'd1);

    // Stall for 5 EXEC cycles with a jr selected: nothing may move
    held_inst = inst;
    stall = 1'b1; pcsrc = 2'b10; ra = 32'h0000_1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst", inst, held_inst);
      chk("stall_pc", pc, 32'h1234_5678);
      chk("stall_ivalid", 32'(inst_valid), 32'd1);
    end
    exec(2'b00, 0);
    chk("post_stall_addr", bus.imem_addr, 32'h1234_567C);

    // Wrap: 0xFFFF_FFFC + 4 = 0x0
    fetch(32'h1234_567C, 32'h0000_0000); exec(2'b10, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h2008_0005);
    chk("wrap_pc4", pc4, 32'h0);
    exec(2'b00, 0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Reset in S_WAIT, then a stale rvalid in the first S_REQ cycle
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    chk("abort_in_wait", 32'(bus.imem_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_rst_ivalid", 32'(inst_valid), 32'd0);
    tick();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("stale_inst", inst, 32'h0);
    chk("stale_ivalid", 32'(inst_valid), 32'd0);
    chk("stale_req", 32'(bus.imem_req), 32'd1);

    // Misaligned jr target traps until reset
    fetch(32'h0, 32'h0100_0008); exec(2'b10, 32'h0000_0102);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_pc", pc, 32'h0);
    chk("mis_req", 32'(bus.imem_req), 32'd0);
    chk("mis_ivalid", 32'(inst_valid), 32'd0);
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("trap_err", 32'(misalign_err), 32'd1);
      chk("trap_req", 32'(bus.imem_req), 32'd0);
    end
    bus.imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("trap_rst_err", 32'(misalign_err), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("trap_exit_req", 32'(bus.imem_req), 32'd1);
    chk("trap_exit_err", 32'(misalign_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the MIPS single-cycle CPU. Owns the PC, fetches instructions through a request/response instruction-memory port, and presents one instruction per execute window to the decoder and control unit. It consumes the control unit's `pcsrc` plus the `jr` register value to compute the next PC. The block sits directly upstream of control decode and closes the PC loop.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch byte address; equals `pc`.
- `imem_ready`  in  1: memory accepts the request this cycle.
- `imem_rvalid`  in  1: read data valid.
- `imem_rdata`  in  32: instruction word.
- `inst`  out  32: latched instruction (IR); `op = inst[31:26]`, `func = inst[5:0]`.
- `pc`  out  32: address of `inst`.
- `pc4`  out  32: `pc + 4`, for `jal` link.
- `inst_valid`  out  1: execute window; downstream gates `wreg`/`wmem` with it.
- `pcsrc`  in  2: next-PC select from the control unit.
- `ra`  in  32: rs register value, the `jr` target.
- `stall`  in  1: extend the execute window (e.g. slow data memory).
- `misalign_err`  out  1: sticky; next PC not word aligned.

## Operation
- FSM states: `S_REQ`, `S_WAIT`, `S_EXEC`, `S_TRAP`.
- `S_REQ`: `imem_req=1`, `imem_addr=pc`. `imem_ready=1` moves to `S_WAIT`; otherwise the request is held stable.
- `S_WAIT`: `imem_req=0`. `imem_rvalid=1` loads IR from `imem_rdata` and moves to `S_EXEC`. `imem_rvalid` is ignored in every other state.
- `S_EXEC`: `inst_valid=1`.
  - `stall=1`: stay in `S_EXEC`; PC and IR hold.
  - `stall=0`: compute `npc`. If `npc[1:0]!=0`, go to `S_TRAP` with PC unchanged. Otherwise load `pc<=npc` and go to `S_REQ`.
- `S_TRAP`: `misalign_err=1`, `imem_req=0`, `inst_valid=0`. Only `rst` exits this state.
- Next PC, all 32-bit modulo 2^32 (wrap silently):
  - `pcsrc=00`: `pc4`
  - `pcsrc=01`: `pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}` (taken branch)
  - `pcsrc=10`: `ra` (jr)
  - `pcsrc=11`: `{pc4[31:28], inst[25:0], 2'b00}` (j/jal)
- `pcsrc` and `ra` are sampled only in `S_EXEC` when `stall=0`.
- Reset values:
  - `pc=RESET_PC`, `inst=0`, state `S_REQ`.
  - Outputs while `rst` is high: `imem_req=0`, `inst_valid=0`, `misalign_err=0`.
- Reset mid-operation (any state) aborts the fetch. A late `imem_rvalid` from the aborted fetch that arrives in `S_REQ` is dropped.

## Timing
- Minimum fetch-to-execute latency is 3 cycles: REQ accepted (cycle 0), rvalid (cycle 1, earliest), EXEC (cycle 2). PC updates at the end of EXEC.
- Throughput without stall or waitstates: one instruction per 3 cycles.
- `imem_rvalid` is never expected in the same cycle as acceptance. Same-cycle rvalid is ignored by design.
- `inst`, `pc` and `pc4` are stable throughout `S_EXEC`, including stalled cycles.
- Registered outputs: `inst`, `pc`, `misalign_err`.
- Combinational from state: `imem_req`, `inst_valid`. Combinational from `pc`: `pc4`, `imem_addr`.
- `rst` has priority over every other event in the same cycle.

## Structure
- Shared package `cpu_pkg`:
  - `pcsrc_t` enum: `PC_SEQ=2'b00`, `PC_BR=2'b01`, `PC_JR=2'b10`, `PC_J=2'b11`. The control unit encodes `pcsrc` to match.
  - `fetch_state_t` enum.
  - Constant `WORD_BYTES=4`.
- One combinational sub-module, `npc_gen`: inputs `pc4`, `inst`, `ra`, `pcsrc`; output `npc`. It is reused by any later pipelined variant.
- The FSM and the PC/IR registers live in `fetch_unit`.

## Test plan
- Reset, 0-waitstate memory returning 32'h2008_0005 (addi) with `pcsrc=00`: `imem_addr` sequence 0x0, 0x4, 0x8; `inst_valid` high every third cycle.
- Branch in EXEC with `pc=0x10`, `inst[15:0]=16'hFFFE`, `pcsrc=01`: next `imem_addr=0x0C`. With `inst[15:0]=16'h0003`: next `imem_addr=0x20`.
- `j` with `pc=0x0040_0000`, `inst[25:0]=26'h0100_0000`, `pcsrc=11`: next `imem_addr=0x0400_0000`. `jr` with `ra=0x1234_5678`, `pcsrc=10`: next `imem_addr=0x1234_5678`.
- `jr` with `ra=0x0000_0102`: `misalign_err` rises the next cycle, `pc` stays, `imem_req` stays 0 until `rst`.
- `imem_ready` low for 3 cycles, then `imem_rvalid` 4 cycles later: `imem_addr` stable while pending. `stall=1` for 5 EXEC cycles: `inst`/`pc` unchanged and a single PC advance afterward.
- Wrap and reset corner cases:
  - `pc=0xFFFF_FFFC`, `pcsrc=00`: next `imem_addr=0x0`.
  - `rst` asserted in `S_WAIT`, then a stale `imem_rvalid` in the first `S_REQ` cycle: `inst` stays 0 and `inst_valid` stays 0.
